mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
Memory-access pipeline stage that consumes the execute stage's registered outputs and drives the data-memory bus.
- Loads and stores use a registered req/ack handshake; byte-enables and store data are lane-aligned, and load data is extracted and sign/zero-extended.
- The writeback value is selected (ALU result, load data, or next_pc) and registered for the writeback stage.
- While a memory transaction is outstanding, a stall is raised to the hazard unit.

Parameters:
- XLEN, 32, data/address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- rd_write_enable  in  1  register write enable from exec.
- rd_write_addr  in  5  destination register.
- res_src  in  2  writeback select: 00 exec result, 01 load data, 10 next_pc.
- mem_write_enable  in  1  store.
- mem_width  in  3  funct3 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- exec_result  in  XLEN  ALU result / effective address.
- mem_write_data  in  XLEN  store data (unaligned, low bits).
- next_pc  in  XLEN  PC+4 for JAL/JALR.
- mem_forward  out  XLEN  combinational copy of exec_result, for exec forwarding.
- stall  out  1  hold upstream stages.
- dmem_req  out  1  request valid (registered).
- dmem_we  out  1  write.
- dmem_addr  out  XLEN  word-aligned address (low 2 bits zero).
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  XLEN  read data, valid with ack.
- dmem_ack  in  1  transaction complete.
- rd_write_enable_out  out  1  to writeback.
- rd_write_addr_out  out  5  to writeback.
- wb_data_out  out  XLEN  selected writeback value.

Behaviour:
- mem_op = mem_write_enable | (res_src==01).
- FSM states: IDLE, WAIT.
  - IDLE, mem_op=1: at the edge, register dmem_req=1 plus dmem_we, dmem_addr, dmem_wdata and dmem_be; go to WAIT.
  - WAIT: dmem_req and all dmem_* outputs are held stable until dmem_ack=1. On the ack edge: dmem_req<=0, go to IDLE, and the writeback regs capture the result.
- stall = mem_op & ~(state==WAIT & dmem_ack), combinational.
  - Stall is high in the IDLE issue cycle and in every WAIT cycle without ack.
  - Upstream inputs are guaranteed stable while stall=1.
- Writeback regs while stalled: rd_write_enable_out<=0 (bubble); wb_data_out holds its value.
- Non-memory ops: one-cycle latency, no bus activity. wb_data_out <= next_pc if res_src==10, otherwise exec_result. res_src==11 gives 0.
- Memory op latency: minimum 2 cycles (issue, then ack in WAIT); extended by each cycle ack is late.
- Address: lane = exec_result[1:0]; dmem_addr = {exec_result[XLEN-1:2],2'b00}.
- Store B: wdata = {4{d[7:0]}}, be = 0001<<lane.
- Store H: wdata = {2{d[15:0]}}, be = 0011<<{lane[1],1'b0}.
- Store W: wdata = d, be = 1111.
- Loads: dmem_be is derived exactly as for stores of the same width.
- Load data extraction:
  - B/BU: byte rdata[8*lane+:8], sign- or zero-extended.
  - H/HU: half rdata[16*lane[1]+:16], sign- or zero-extended.
  - W: full word.
- Stores: rd_write_enable_out <= rd_write_enable (expected 0).
- Reset: state=IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, rd_write_enable_out=0, rd_write_addr_out=0, wb_data_out=0.
- Reset asserted mid-WAIT abandons the transaction. A stray ack arriving in IDLE is ignored.
- Ack in the IDLE issue cycle is ignored; only ack in WAIT completes a transaction.
- Invalid mem_width codes are treated as W.

Optional Feature:
- Macro MEM_MISALIGN_CHECK_EN.
- When defined: H with lane[0]=1, or W with lane!=00, is misaligned. For a misaligned op:
  - no bus request, no stall; completes in one cycle;
  - rd_write_enable_out<=0;
  - extra output port misaligned (1 bit) pulses high for one cycle, registered alongside the writeback regs.
- When undefined: the port is absent and the low address bits are ignored (H uses lane[1]; W is always full-word).

Decomposition:
- Width codes and res_src codes belong as shared `define constants in the common constants header, alongside the existing ALU op codes.
- One sub-module, load_align: combinational (rdata, lane, mem_width) -> extended load value.
- Store lane/byte-enable logic stays inline.

Test Plan:
- ADD result 0x0000_1234, res_src=00, rd=5: next cycle rd_write_enable_out=1, rd_write_addr_out=5, wb_data_out=0x1234; dmem_req stays 0; stall stays 0.
- SB, addr 0x103, data 0xAB: dmem_addr=0x100, be=1000, wdata=0xABABABAB. Ack 3 cycles after req: stall high for 4 cycles, req drops after ack.
- LB, addr 0x102, rdata 0x0080_0000, ack in first WAIT cycle: wb_data_out=0xFFFF_FF80. Repeated as LBU: 0x0000_0080. Total latency 2 cycles.
- LH, addr 0x2, rdata 0x8001_0000: wb_data_out=0xFFFF_8001, be=1100.
- JAL with res_src=10, next_pc=0x44: wb_data_out=0x44, no bus activity. rst_n low during a LW in WAIT: next cycle dmem_req=0, state IDLE; a late ack produces no writeback.
- With MEM_MISALIGN_CHECK_EN: LW at 0x6 -> misaligned=1 for one cycle, dmem_req=0, rd_write_enable_out=0, stall=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared codes for the memory-access stage: funct3 width codes, writeback select codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_access_pkg;

    // funct3 width codes for loads and stores
    localparam logic [2:0] MW_B  = 3'b000;
    localparam logic [2:0] MW_H  = 3'b001;
    localparam logic [2:0] MW_W  = 3'b010;
    localparam logic [2:0] MW_BU = 3'b100;
    localparam logic [2:0] MW_HU = 3'b101;

    // writeback source select
    localparam logic [1:0] RS_EXEC = 2'b00;
    localparam logic [1:0] RS_LOAD = 2'b01;
    localparam logic [1:0] RS_PC   = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Collapse signed/unsigned variants to an access size; unknown codes act as a full word.
    function automatic size_e width_size(input logic [2:0] w);
        case (w)
            MW_B, MW_BU: width_size = SZ_B;
            MW_H, MW_HU: width_size = SZ_H;
            default:     width_size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Extracts the addressed byte/half/word from a read word and sign- or zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
module load_align
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      lane,
    input  logic [2:0]      mem_width,
    output logic [XLEN-1:0] load_val
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the lane and extend according to the width code
    always_comb begin
        byte_v = rdata[{lane, 3'b000} +: 8];
        half_v = rdata[{lane[1], 4'b0000} +: 16];
        case (mem_width)
            MW_B:    load_val = {{(XLEN-8){byte_v[7]}}, byte_v};
            MW_BU:   load_val = {{(XLEN-8){1'b0}}, byte_v};
            MW_H:    load_val = {{(XLEN-16){half_v[15]}}, half_v};
            MW_HU:   load_val = {{(XLEN-16){1'b0}}, half_v};
            default: load_val = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: issues registered dmem req/ack transactions and registers the writeback value.
// Latency: 1 cycle for non-memory ops, >=2 cycles for loads/stores (issue + ack in WAIT).
// Backpressure: stall held high from issue until the ack cycle; MEM_MISALIGN_CHECK_EN adds misaligned trap.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_write_enable,
    input  logic [4:0]      rd_write_addr,
    input  logic [1:0]      res_src,
    input  logic            mem_write_enable,
    input  logic [2:0]      mem_width,
    input  logic [XLEN-1:0] exec_result,
    input  logic [XLEN-1:0] mem_write_data,
    input  logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] mem_forward,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            rd_write_enable_out,
    output logic [4:0]      rd_write_addr_out,
    output logic [XLEN-1:0] wb_data_out
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic            misaligned
`endif
);

    state_e          state_q, state_d;
    logic            dmem_req_q, dmem_req_d;
    logic            dmem_we_q, dmem_we_d;
    logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
    logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]      dmem_be_q, dmem_be_d;
    logic            rd_we_out_q, rd_we_out_d;
    logic [4:0]      rd_addr_out_q, rd_addr_out_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic [1:0]      lane;
    size_e           size;
    logic            mem_op;
    logic            misalign_op;
    logic            mem_go;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] st_wdata;
    logic [3:0]      st_be;
    logic [XLEN-1:0] wb_sel;

    assign lane        = exec_result[1:0];
    assign size        = width_size(mem_width);
    assign mem_op      = mem_write_enable | (res_src == RS_LOAD);
    assign mem_forward = exec_result;

`ifdef MEM_MISALIGN_CHECK_EN
    // Misaligned halves/words are trapped locally and never reach the bus
    assign misalign_op = mem_op & (((size == SZ_H) & lane[0]) | ((size == SZ_W) & (lane != 2'b00)));
`else
    assign misalign_op = 1'b0;
`endif

    assign mem_go = mem_op & ~misalign_op;
    assign stall  = mem_go & ~((state_q == ST_WAIT) & dmem_ack);

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata     (dmem_rdata),
        .lane      (lane),
        .mem_width (mem_width),
        .load_val  (load_val)
    );

    // Lane-replicate store data and derive byte enables (loads reuse the same enables)
    always_comb begin
        st_wdata = mem_write_data;
        st_be    = 4'b1111;
        case (size)
            SZ_B: begin
                st_wdata = {(XLEN/8){mem_write_data[7:0]}};
                st_be    = 4'b0001 << lane;
            end
            SZ_H: begin
                st_wdata = {(XLEN/16){mem_write_data[15:0]}};
                st_be    = 4'b0011 << {lane[1], 1'b0};
            end
            default: begin
                st_wdata = mem_write_data;
                st_be    = 4'b1111;
            end
        endcase
    end

    // Writeback source select; the unused code yields zero
    always_comb begin
        case (res_src)
            RS_EXEC: wb_sel = exec_result;
            RS_LOAD: wb_sel = load_val;
            RS_PC:   wb_sel = next_pc;
            default: wb_sel = '0;
        endcase
    end

    // Bus FSM next state: issue from IDLE, hold everything stable in WAIT until ack
    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_go) begin
                    state_d      = ST_WAIT;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = mem_write_enable;
                    dmem_addr_d  = {exec_result[XLEN-1:2], 2'b00};
                    dmem_wdata_d = st_wdata;
                    dmem_be_d    = st_be;
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    state_d    = ST_IDLE;
                    dmem_req_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Writeback next state: bubble while stalled, suppress write on a trapped access
    always_comb begin
        rd_we_out_d   = 1'b0;
        rd_addr_out_d = rd_addr_out_q;
        wb_data_d     = wb_data_q;
        if (!stall) begin
            rd_addr_out_d = rd_write_addr;
            if (!misalign_op) begin
                rd_we_out_d = rd_write_enable;
                wb_data_d   = wb_sel;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= '0;
            dmem_wdata_q  <= '0;
            dmem_be_q     <= 4'b0000;
            rd_we_out_q   <= 1'b0;
            rd_addr_out_q <= 5'd0;
            wb_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            dmem_req_q    <= dmem_req_d;
            dmem_we_q     <= dmem_we_d;
            dmem_addr_q   <= dmem_addr_d;
            dmem_wdata_q  <= dmem_wdata_d;
            dmem_be_q     <= dmem_be_d;
            rd_we_out_q   <= rd_we_out_d;
            rd_addr_out_q <= rd_addr_out_d;
            wb_data_q     <= wb_data_d;
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;

    assign misaligned_d = misalign_op;

    // One-cycle misaligned pulse, aligned with the writeback registers
    always_ff @(posedge clk) begin
        if (!rst_n) misaligned_q <= 1'b0;
        else        misaligned_q <= misaligned_d;
    end

    assign misaligned = misaligned_q;
`endif

    assign dmem_req            = dmem_req_q;
    assign dmem_we             = dmem_we_q;
    assign dmem_addr           = dmem_addr_q;
    assign dmem_wdata          = dmem_wdata_q;
    assign dmem_be             = dmem_be_q;
    assign rd_write_enable_out = rd_we_out_q;
    assign rd_write_addr_out   = rd_addr_out_q;
    assign wb_data_out         = wb_data_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU/JAL writeback, loads, stores, late/early ack, reset mid-transaction.
// Inputs change 1ns after posedge; outputs are checked on the negedge.
// Define MEM_MISALIGN_CHECK_EN to also exercise the misaligned trap.
module tb_mem_access;

    logic        clk;
    logic        rst_n;
    logic        rd_write_enable;
    logic [4:0]  rd_write_addr;
    logic [1:0]  res_src;
    logic        mem_write_enable;
    logic [2:0]  mem_width;
    logic [31:0] exec_result;
    logic [31:0] mem_write_data;
    logic [31:0] next_pc;
    logic [31:0] mem_forward;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        rd_write_enable_out;
    logic [4:0]  rd_write_addr_out;
    logic [31:0] wb_data_out;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misaligned;
`endif

    int vectors;
    int miscompares;

    mem_access #(.XLEN(32)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .rd_write_enable     (rd_write_enable),
        .rd_write_addr       (rd_write_addr),
        .res_src             (res_src),
        .mem_write_enable    (mem_write_enable),
        .mem_width           (mem_width),
        .exec_result         (exec_result),
        .mem_write_data      (mem_write_data),
        .next_pc             (next_pc),
        .mem_forward         (mem_forward),
        .stall               (stall),
        .dmem_req            (dmem_req),
        .dmem_we             (dmem_we),
        .dmem_addr           (dmem_addr),
        .dmem_wdata          (dmem_wdata),
        .dmem_be             (dmem_be),
        .dmem_rdata          (dmem_rdata),
        .dmem_ack            (dmem_ack),
        .rd_write_enable_out (rd_write_enable_out),
        .rd_write_addr_out   (rd_write_addr_out),
        .wb_data_out         (wb_data_out)
`ifdef MEM_MISALIGN_CHECK_EN
        ,
        .misaligned          (misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        rd_write_enable  = 1'b0;
        rd_write_addr    = 5'd0;
        res_src          = 2'b00;
        mem_write_enable = 1'b0;
        mem_width        = 3'b010;
        exec_result      = 32'h0;
        mem_write_data   = 32'h0;
        next_pc          = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        set_nop();
        tick();
        tick();
        @(negedge clk);
        vectors++;
        if ({dmem_req, dmem_we, dmem_be} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_bus req/we/be=%b want 0", {dmem_req, dmem_we, dmem_be});
        end
        vectors++;
        if ({dmem_addr, dmem_wdata} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_addr_wdata got %h/%h want 0", dmem_addr, dmem_wdata);
        end
        vectors++;
        if ({rd_write_enable_out, rd_write_addr_out, wb_data_out} !== 38'h0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wb got we=%b rd=%0d wb=%h stall=%b want all 0",
                     rd_write_enable_out, rd_write_addr_out, wb_data_out, stall);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        rd_write_enable = 1'b1;
        rd_write_addr   = 5'd5;
        res_src         = 2'b00;
        exec_result     = 32'h0000_1234;
        next_pc         = 32'h0000_0088;
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0 || mem_forward !== 32'h1234) begin
            miscompares++;
            $display("FAIL alu_issue stall=%b fwd=%h want 0/00001234", stall, mem_forward);
        end
        tick();
        set_nop();
        @(negedge clk);
        vectors++;
        if (rd_write_enable_out !== 1'b1 || rd_write_addr_out !== 5'd5 || wb_data_out !== 32'h1234) begin
            miscompares++;
            $display("FAIL alu_wb we=%b rd=%0d wb=%h want 1/5/00001234",
                     rd_write_enable_out, rd_write_addr_out, wb_data_out);
        end
        vectors++;
        if (dmem_req !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_nobus req=%b stall=%b want 0/0", dmem_req, stall);
        end
        tick();
    endtask

    task automatic test_jal();
        rd_write_enable = 1'b1;
        rd_write_addr   = 5'd1;
        res_src         = 2'b10;
        exec_result     = 32'h0000_0999;
        next_pc         = 32'h0000_0044;
        tick();
        res_src = 2'b11;
        @(negedge clk);
        vectors++;
        if (wb_data_out !== 32'h44 || rd_write_enable_out !== 1'b1 || dmem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL jal_wb wb=%h we=%b req=%b want 00000044/1/0",
                     wb_data_out, rd_write_enable_out, dmem_req);
        end
        tick();
        set_nop();
        @(negedge clk);
        vectors++;
        if (wb_data_out !== 32'h0) begin
            miscompares++;
            $display("FAIL res_src11_wb got %h want 00000000", wb_data_out);
        end
        tick();
    endtask

    task automatic test_store_late_ack();
        int stall_cnt;
        stall_cnt        = 0;
        mem_write_enable = 1'b1;
        mem_width        = 3'b000;
        exec_result      = 32'h0000_0103;
        mem_write_data   = 32'h1234_56AB;
        for (int i = 0; i < 5; i++) begin
            dmem_ack = (i == 4);
            @(negedge clk);
            if (stall) stall_cnt++;
            if (i == 1) begin
                vectors++;
                if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h100) begin
                    miscompares++;
                    $display("FAIL sb_req req=%b we=%b addr=%h want 1/1/00000100", dmem_req, dmem_we, dmem_addr);
                end
                vectors++;
                if (dmem_be !== 4'b1000 || dmem_wdata !== 32'hABAB_ABAB) begin
                    miscompares++;
                    $display("FAIL sb_lanes be=%b wdata=%h want 1000/abababab", dmem_be, dmem_wdata);
                end
            end
            if (i == 4) begin
                vectors++;
                if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || stall !== 1'b0) begin
                    miscompares++;
                    $display("FAIL sb_hold req=%b addr=%h stall=%b want 1/00000100/0", dmem_req, dmem_addr, stall);
                end
            end
            tick();
        end
        set_nop();
        dmem_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (stall_cnt !== 4) begin
            miscompares++;
            $display("FAIL sb_stall_cycles got %0d want 4", stall_cnt);
        end
        vectors++;
        if (dmem_req !== 1'b0 || rd_write_enable_out !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_done req=%b we_out=%b want 0/0", dmem_req, rd_write_enable_out);
        end
        tick();
    endtask

    task automatic do_store(input string name, input logic [2:0] w, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] exp_wdata, input logic [3:0] exp_be);
        mem_write_enable = 1'b1;
        mem_width        = w;
        exec_result      = addr;
        mem_write_data   = data;
        tick();
        dmem_ack = 1'b1;
        @(negedge clk);
        vectors++;
        if (dmem_wdata !== exp_wdata || dmem_be !== exp_be || dmem_addr !== {addr[31:2], 2'b00}) begin
            miscompares++;
            $display("FAIL %s wdata=%h be=%b addr=%h want %h/%b/%h", name, dmem_wdata, dmem_be,
                     dmem_addr, exp_wdata, exp_be, {addr[31:2], 2'b00});
        end
        tick();
        dmem_ack = 1'b0;
        set_nop();
    endtask

    task automatic do_load(input string name, input logic [2:0] w, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_wb, input logic [3:0] exp_be);
        rd_write_enable = 1'b1;
        rd_write_addr   = 5'd7;
        res_src         = 2'b01;
        mem_width       = w;
        exec_result     = addr;
        @(negedge clk);
        vectors++;
        if (stall !== 1'b1 || dmem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_issue stall=%b req=%b want 1/0", name, stall, dmem_req);
        end
        tick();
        dmem_rdata = rdata;
        dmem_ack   = 1'b1;
        @(negedge clk);
        vectors++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_be !== exp_be || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_bus req=%b we=%b be=%b stall=%b want 1/0/%b/0",
                     name, dmem_req, dmem_we, dmem_be, stall, exp_be);
        end
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        set_nop();
        @(negedge clk);
        vectors++;
        if (wb_data_out !== exp_wb || rd_write_enable_out !== 1'b1 || rd_write_addr_out !== 5'd7
            || dmem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_wb wb=%h we=%b rd=%0d req=%b want %h/1/7/0", name, wb_data_out,
                     rd_write_enable_out, rd_write_addr_out, dmem_req, exp_wb);
        end
        tick();
    endtask

    task automatic test_early_ack();
        rd_write_enable = 1'b1;
        rd_write_addr   = 5'd9;
        res_src         = 2'b01;
        mem_width       = 3'b010;
        exec_result     = 32'h0000_0200;
        dmem_rdata      = 32'hCAFE_F00D;
        dmem_ack        = 1'b1;
        tick();
        dmem_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (dmem_req !== 1'b1 || stall !== 1'b1 || rd_write_enable_out !== 1'b0) begin
            miscompares++;
            $display("FAIL early_ack_ignored req=%b stall=%b we_out=%b want 1/1/0",
                     dmem_req, stall, rd_write_enable_out);
        end
        tick();
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        set_nop();
        @(negedge clk);
        vectors++;
        if (wb_data_out !== 32'hCAFE_F00D || rd_write_enable_out !== 1'b1 || dmem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL early_ack_done wb=%h we=%b req=%b want cafef00d/1/0",
                     wb_data_out, rd_write_enable_out, dmem_req);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        rd_write_enable = 1'b1;
        rd_write_addr   = 5'd3;
        res_src         = 2'b01;
        mem_width       = 3'b010;
        exec_result     = 32'h0000_0300;
        tick();
        @(negedge clk);
        vectors++;
        if (dmem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_wait_req got %b want 1", dmem_req);
        end
        tick();
        rst_n = 1'b0;
        set_nop();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (dmem_req !== 1'b0 || stall !== 1'b0 || wb_data_out !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_abandon req=%b stall=%b wb=%h want 0/0/0", dmem_req, stall, wb_data_out);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555_5555;
        tick();
        dmem_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (rd_write_enable_out !== 1'b0 || wb_data_out !== 32'h0 || dmem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_ack we=%b wb=%h req=%b want 0/0/0", rd_write_enable_out, wb_data_out, dmem_req);
        end
        tick();
    endtask

`ifdef MEM_MISALIGN_CHECK_EN
    task automatic test_misalign();
        rd_write_enable = 1'b1;
        rd_write_addr   = 5'd4;
        res_src         = 2'b01;
        mem_width       = 3'b010;
        exec_result     = 32'h0000_0006;
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_stall got %b want 0", stall);
        end
        tick();
        set_nop();
        @(negedge clk);
        vectors++;
        if (misaligned !== 1'b1 || dmem_req !== 1'b0 || rd_write_enable_out !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_pulse mis=%b req=%b we=%b want 1/0/0", misaligned, dmem_req, rd_write_enable_out);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (misaligned !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_one_cycle got %b want 0", misaligned);
        end
        tick();
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_alu();
        test_jal();
        test_store_late_ack();
        do_store("sh", 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'hABCD_ABCD, 4'b1100);
        do_store("sw", 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111);
        do_load("lb",  3'b000, 32'h0000_0102, 32'h0080_0000, 32'hFFFF_FF80, 4'b0100);
        do_load("lbu", 3'b100, 32'h0000_0102, 32'h0080_0000, 32'h0000_0080, 4'b0100);
        do_load("lh",  3'b001, 32'h0000_0002, 32'h8001_0000, 32'hFFFF_8001, 4'b1100);
        do_load("lhu", 3'b101, 32'h0000_0000, 32'h0000_F00F, 32'h0000_F00F, 4'b0011);
        do_load("lw_bad_width", 3'b011, 32'h0000_0040, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111);
        test_early_ack();
        test_reset_mid_wait();
`ifdef MEM_MISALIGN_CHECK_EN
        test_misalign();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
